// File: rtl/calc_pkg.sv
// calc_pkg: shared state/op encodings and default key codes for the calculator sequencer
package calc_pkg;

    typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, SHOW, ERR} state_t;

    typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_t;

    localparam logic [3:0] DEF_KEY_ADD = 4'hA;
    localparam logic [3:0] DEF_KEY_SUB = 4'hB;
    localparam logic [3:0] DEF_KEY_EQ  = 4'hC;
    localparam logic [3:0] DEF_KEY_CLR = 4'hD;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

endpackage

// File: rtl/key_event_detect.sv
// key_event_detect: one registered pulse per rising edge of key_trig, with the code captured on that edge
module key_event_detect (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       key_trig,
    input  logic [3:0] key_code,
    output logic       key_evt,
    output logic [3:0] evt_code
);

    logic trig_d;

    // delay key_trig one cycle and flag the first cycle it is seen high
    always_ff @(posedge CLK) begin
        if (RESET) begin
            trig_d   <= 1'b0;
            key_evt  <= 1'b0;
            evt_code <= 4'd0;
        end else begin
            trig_d   <= key_trig;
            key_evt  <= key_trig & ~trig_d;
            evt_code <= key_code;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operand/operator sequencing for the add/sub ALU; CALC_CHAIN_EN enables chained operations from SHOW
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int         W       = 8,
    parameter int         ALU_LAT = 1,
    parameter logic [3:0] KEY_ADD = DEF_KEY_ADD,
    parameter logic [3:0] KEY_SUB = DEF_KEY_SUB,
    parameter logic [3:0] KEY_EQ  = DEF_KEY_EQ,
    parameter logic [3:0] KEY_CLR = DEF_KEY_CLR
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         key_trig,
    input  logic [3:0]   key_code,
    input  logic [W-1:0] operand_in,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic         clear_entry,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         op_sub,
    output logic         alu_start,
    output logic [W-1:0] disp_value,
    output logic         busy,
    output logic         err
);

    state_t       state, state_n;
    logic         evt;
    logic [3:0]   code;
    logic [W-1:0] res, res_n, op_a_n, op_b_n, disp_n;
    logic [3:0]   cnt, cnt_n;
    logic         op_sub_n, clear_n, start_n, is_op;

    key_event_detect u_key (
        .CLK      (CLK),
        .RESET    (RESET),
        .key_trig (key_trig),
        .key_code (key_code),
        .key_evt  (evt),
        .evt_code (code)
    );

    assign is_op = evt && (code == KEY_ADD || code == KEY_SUB);

    // next state and next register values; clear outranks everything, including ALU completion
    always_comb begin
        state_n  = state;
        op_a_n   = op_a;
        op_b_n   = op_b;
        op_sub_n = op_sub;
        res_n    = res;
        cnt_n    = cnt;
        clear_n  = 1'b0;
        start_n  = 1'b0;
        if (evt && code == KEY_CLR) begin
            state_n = ENTER_A;
            clear_n = 1'b1;
            op_a_n  = '0;
            op_b_n  = '0;
            res_n   = '0;
        end else begin
            case (state)
                ENTER_A: if (is_op) begin
                    op_a_n   = operand_in;
                    op_sub_n = (code == KEY_SUB) ? SUB : ADD;
                    clear_n  = 1'b1;
                    state_n  = ENTER_B;
                end
                ENTER_B: if (is_op) begin
                    op_sub_n = (code == KEY_SUB) ? SUB : ADD;
                end else if (evt && code == KEY_EQ) begin
                    op_b_n  = operand_in;
                    start_n = 1'b1;
                    cnt_n   = 4'(ALU_LAT);
                    state_n = EXEC;
                end
                EXEC: if (cnt == 4'd0) begin
                    state_n = alu_ovf ? ERR : SHOW;
                    res_n   = alu_ovf ? res : alu_result;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
                SHOW: if (evt && is_digit(code)) begin
                    clear_n = 1'b1;
                    state_n = ENTER_A;
                end
`ifdef CALC_CHAIN_EN
                else if (is_op) begin
                    op_a_n   = res;
                    op_sub_n = (code == KEY_SUB) ? SUB : ADD;
                    clear_n  = 1'b1;
                    state_n  = ENTER_B;
                end
`endif
                default: ;
            endcase
        end
        disp_n = (state_n == SHOW) ? res_n :
                 (state_n == EXEC) ? op_b_n :
                 (state_n == ERR)  ? '0 : operand_in;
    end

    // state, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ENTER_A;
            op_a        <= '0;
            op_b        <= '0;
            op_sub      <= 1'b0;
            res         <= '0;
            cnt         <= 4'd0;
            clear_entry <= 1'b0;
            alu_start   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            disp_value  <= '0;
        end else begin
            state       <= state_n;
            op_a        <= op_a_n;
            op_b        <= op_b_n;
            op_sub      <= op_sub_n;
            res         <= res_n;
            cnt         <= cnt_n;
            clear_entry <= clear_n;
            alu_start   <= start_n;
            busy        <= (state_n == EXEC);
            err         <= (state_n == ERR);
            disp_value  <= disp_n;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scoreboard bench for calc_sequencer with a latency-accurate ALU model
module tb_calc_sequencer;

    localparam int         LAT   = 3;
    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CLR = 4'hD;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       key_trig = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [7:0] operand_in = 8'd0;
    logic [7:0] alu_result = 8'h55;
    logic       alu_ovf = 1'b0;
    logic       clear_entry, op_sub, alu_start, busy, err;
    logic [7:0] op_a, op_b, disp_value;

    typedef struct {
        logic [7:0] disp;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   ce_cnt = 0;
    int   as_cnt = 0;
    int   ce0, as0;
    int   k = 0;
    logic [7:0] alu_s, alu_bv;
    logic       alu_o;

    calc_sequencer #(.W(8), .ALU_LAT(LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .key_trig    (key_trig),
        .key_code    (key_code),
        .operand_in  (operand_in),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .clear_entry (clear_entry),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sub      (op_sub),
        .alu_start   (alu_start),
        .disp_value  (disp_value),
        .busy        (busy),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (clear_entry === 1'b1) ce_cnt++;
        if (alu_start === 1'b1) as_cnt++;
    end

    // ALU model: result valid only LAT cycles after alu_start, garbage otherwise
    always @(negedge CLK) begin
        if (alu_start === 1'b1) begin
            k      = LAT;
            alu_bv = op_sub ? ~op_b : op_b;
            alu_s  = op_sub ? op_a - op_b : op_a + op_b;
            alu_o  = (op_a[7] == alu_bv[7]) && (alu_s[7] != op_a[7]);
            alu_result = 8'h55;
            alu_ovf    = 1'b0;
        end else if (k > 0) begin
            k--;
            if (k == 0) begin
                alu_result = alu_s;
                alu_ovf    = alu_o;
            end
        end else begin
            alu_result = 8'h55;
            alu_ovf    = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] c, input int hold);
        @(negedge CLK);
        key_code = c;
        key_trig = 1'b1;
        repeat (hold) @(negedge CLK);
        key_trig = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic finish_calc(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        chk({tag, "_timeout"}, 9'(n < 60), 9'd1);
        chk({tag, "_sb_nonempty"}, 9'(sb.size() > 0), 9'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_disp"}, 9'(disp_value), 9'(e.disp));
            chk({tag, "_err"}, 9'(err), 9'(e.err));
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (alu_start !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_start_seen"}, 9'(n < 20), 9'd1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_op_a", 9'(op_a), 9'd0);
        chk("rst_op_b", 9'(op_b), 9'd0);
        chk("rst_op_sub", 9'(op_sub), 9'd0);
        chk("rst_clear", 9'(clear_entry), 9'd0);
        chk("rst_start", 9'(alu_start), 9'd0);
        chk("rst_busy", 9'(busy), 9'd0);
        chk("rst_err", 9'(err), 9'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // basic add 25 + 17
        operand_in = 8'd25;
        ce0 = ce_cnt;
        press(K_ADD, 1);
        chk("add_clear_once", 9'(ce_cnt - ce0), 9'd1);
        chk("add_op_a", 9'(op_a), 9'd25);
        chk("add_op_sub", 9'(op_sub), 9'd0);
        operand_in = 8'd17;
        @(negedge CLK);
        @(negedge CLK);
        chk("add_disp_entry", 9'(disp_value), 9'd17);
        as0 = as_cnt;
        sb.push_back('{8'd42, 1'b0});
        press(K_EQ, 1);
        finish_calc("add");
        chk("add_one_start", 9'(as_cnt - as0), 9'd1);
        chk("add_op_b", 9'(op_b), 9'd17);
        chk("add_clear_total", 9'(ce_cnt - ce0), 9'd1);

        // digit in SHOW returns to ENTER_A
        operand_in = 8'd99;
        ce0 = ce_cnt;
        press(4'd7, 1);
        chk("show_digit_clear", 9'(ce_cnt - ce0), 9'd1);
        chk("show_digit_disp", 9'(disp_value), 9'd99);

        // subtract to negative 10 - 30
        operand_in = 8'd10;
        press(K_SUB, 1);
        chk("sub_op_sub", 9'(op_sub), 9'd1);
        operand_in = 8'd30;
        sb.push_back('{8'hEC, 1'b0});
        press(K_EQ, 1);
        finish_calc("sub");
        press(4'd1, 1);

        // overflow 99 + 99
        operand_in = 8'd99;
        press(K_ADD, 1);
        sb.push_back('{8'd0, 1'b1});
        press(K_EQ, 1);
        finish_calc("ovf");
        ce0 = ce_cnt;
        as0 = as_cnt;
        press(4'd5, 1);
        press(K_ADD, 1);
        press(K_EQ, 1);
        chk("ovf_err_held", 9'(err), 9'd1);
        chk("ovf_disp_zero", 9'(disp_value), 9'd0);
        chk("ovf_no_clear", 9'(ce_cnt - ce0), 9'd0);
        chk("ovf_no_start", 9'(as_cnt - as0), 9'd0);
        operand_in = 8'd33;
        press(K_CLR, 1);
        chk("ovf_clr_err", 9'(err), 9'd0);
        chk("ovf_clr_disp", 9'(disp_value), 9'd33);
        chk("ovf_clr_pulse", 9'(ce_cnt - ce0), 9'd1);

        // held keys produce one event each
        operand_in = 8'd50;
        ce0 = ce_cnt;
        press(K_ADD, 10);
        chk("held_add_clear", 9'(ce_cnt - ce0), 9'd1);
        chk("held_add_op_a", 9'(op_a), 9'd50);
        ce0 = ce_cnt;
        press(K_CLR, 10);
        chk("held_clr_clear", 9'(ce_cnt - ce0), 9'd1);
        chk("held_clr_op_a", 9'(op_a), 9'd0);

        // clear lands on the ALU completion cycle
        operand_in = 8'd5;
        press(K_ADD, 1);
        operand_in = 8'd6;
        @(negedge CLK);
        key_code = K_EQ;
        key_trig = 1'b1;
        @(negedge CLK);
        key_trig = 1'b0;
        wait_start("cvc");
        operand_in = 8'd77;
        ce0 = ce_cnt;
        @(negedge CLK);
        @(negedge CLK);
        key_code = K_CLR;
        key_trig = 1'b1;
        @(negedge CLK);
        key_trig = 1'b0;
        repeat (3) @(negedge CLK);
        chk("cvc_busy", 9'(busy), 9'd0);
        chk("cvc_err", 9'(err), 9'd0);
        chk("cvc_disp", 9'(disp_value), 9'd77);
        chk("cvc_op_b", 9'(op_b), 9'd0);
        chk("cvc_clear", 9'(ce_cnt - ce0), 9'd1);

        // reset mid-EXEC aborts the operation
        operand_in = 8'd1;
        press(K_ADD, 1);
        operand_in = 8'd2;
        @(negedge CLK);
        key_code = K_EQ;
        key_trig = 1'b1;
        @(negedge CLK);
        key_trig = 1'b0;
        wait_start("rx");
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        operand_in = 8'd64;
        repeat (6) @(negedge CLK);
        chk("rx_busy", 9'(busy), 9'd0);
        chk("rx_disp", 9'(disp_value), 9'd64);
        chk("rx_op_b", 9'(op_b), 9'd0);

        // operator key in SHOW: chained or ignored
        operand_in = 8'd5;
        press(K_ADD, 1);
        operand_in = 8'd3;
        sb.push_back('{8'd8, 1'b0});
        press(K_EQ, 1);
        finish_calc("ch1");
        operand_in = 8'd2;
        ce0 = ce_cnt;
        press(K_ADD, 1);
`ifdef CALC_CHAIN_EN
        chk("chain_op_a", 9'(op_a), 9'd8);
        chk("chain_clear", 9'(ce_cnt - ce0), 9'd1);
        chk("chain_disp", 9'(disp_value), 9'd2);
        sb.push_back('{8'd10, 1'b0});
        press(K_EQ, 1);
        finish_calc("ch2");
`else
        chk("nochain_disp", 9'(disp_value), 9'd8);
        chk("nochain_clear", 9'(ce_cnt - ce0), 9'd0);
        chk("nochain_op_a", 9'(op_a), 9'd5);
        press(4'd4, 1);
        chk("nochain_exit", 9'(disp_value), 9'd2);
`endif
        chk("sb_drained", 9'(sb.size()), 9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level operation controller for the eight-bit two-function (add/subtract) calculator.
- Watches keypad command events from the input unit, latches operand A/B (8-bit two's complement) and the operator, launches the ALU, captures result/overflow, and drives the display source select.
- Sits between the input unit, the add/sub ALU and the seven-segment display driver.

Parameters:
- W, 8, operand/result width (two's complement)
- ALU_LAT, 1, cycles from alu_start to valid alu_result/alu_ovf (1..15)
- KEY_ADD, 4'hA, key code for add
- KEY_SUB, 4'hB, key code for subtract
- KEY_EQ, 4'hC, key code for equals
- KEY_CLR, 4'hD, key code for clear

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- key_trig  in  1  keypad event strobe from input unit; level may last several cycles
- key_code  in  4  key value, valid while key_trig high
- operand_in  in  W  current entry value, two's complement, from input unit
- alu_result  in  W  ALU result
- alu_ovf  in  1  ALU signed overflow, valid with alu_result
- clear_entry  out  1  one-cycle pulse; input unit clears its digit buffer
- op_a  out  W  latched operand A
- op_b  out  W  latched operand B
- op_sub  out  1  0 = add, 1 = subtract
- alu_start  out  1  one-cycle ALU launch pulse
- disp_value  out  W  value for the display
- busy  out  1  high in EXEC
- err  out  1  high in ERR

Behaviour:
- All outputs registered. Reset values: state ENTER_A, op_a = op_b = 0, op_sub = 0, result register = 0, clear_entry = alu_start = busy = err = 0.
- Key event: rising edge of key_trig, detected against a 1-cycle delayed copy. key_code is sampled on that edge cycle. Holding key_trig high produces exactly one event.
- State transitions occur on the clock edge following the event cycle.
- Digit codes (0-9) and 4'hE/4'hF are never commands. The input unit consumes the digits.
- KEY_CLR in any state: go to ENTER_A, pulse clear_entry, zero op_a, op_b and the result register, clear err. Clear has priority over every other condition in the same cycle, including ALU completion.
- ENTER_A:
  - KEY_ADD/KEY_SUB: op_a <= operand_in; op_sub <= (code == KEY_SUB); pulse clear_entry; go to ENTER_B.
  - KEY_EQ is ignored.
- ENTER_B:
  - KEY_ADD/KEY_SUB: only update op_sub; stay in ENTER_B.
  - KEY_EQ: op_b <= operand_in; go to EXEC.
- EXEC:
  - First cycle: alu_start = 1; counter loaded with ALU_LAT.
  - Counter decrements each cycle. When it reaches 0, sample alu_result/alu_ovf. ovf = 1 goes to ERR; otherwise result register <= alu_result and go to SHOW.
  - busy = 1 throughout EXEC. Non-clear keys are dropped, not queued.
- SHOW:
  - Digit key: pulse clear_entry, go to ENTER_A. That digit is discarded.
  - KEY_EQ: ignored.
  - Operator keys: see Optional Feature.
- ERR: err = 1. Only KEY_CLR exits.
- disp_value by state:
  - ENTER_A/ENTER_B: operand_in.
  - EXEC: op_b.
  - SHOW: result register.
  - ERR: 0.
- Width rule: no arithmetic is performed here. Operands are passed as-is, and the W-bit two's complement range is the ALU's concern.
- RESET asserted mid-EXEC aborts the operation. The late ALU result is ignored.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: in SHOW, KEY_ADD/KEY_SUB sets op_a <= result register, sets op_sub, pulses clear_entry, and goes to ENTER_B, giving chained calculations (5+3=+2=).
- Undefined: operator keys in SHOW are ignored; only a digit key or clear leaves SHOW.

Decomposition:
- Package calc_pkg:
  - state encoding: ENTER_A, ENTER_B, EXEC, SHOW, ERR.
  - default key-code constants.
  - op encoding: ADD = 0, SUB = 1.
- Sub-module key_event_detect: registers key_trig, outputs a one-cycle key_evt pulse and the latched key_code. This isolates the edge/hold behaviour for separate test.

Test Plan:
- Basic add: operand_in = 25, key A; operand_in = 17, key C; ALU_LAT = 1, ALU returns 42 → exactly one alu_start pulse, op_a = 25, op_b = 17, op_sub = 0, state SHOW, disp_value = 42, clear_entry pulsed once after A.
- Subtract to negative: 10 − 30 → op_sub = 1, ALU returns 8'hEC, disp_value = 8'hEC (−20).
- Overflow: 99 + 99, ALU asserts alu_ovf → err = 1, disp_value = 0; keys 5/A/C ignored; key D → ENTER_A, err = 0.
- Held key: key_trig high for 10 cycles with code A → single transition, single clear_entry pulse.
- Clear versus completion: ALU_LAT = 3, key D arrives on the completion cycle → ENTER_A, result register = 0, no SHOW.
- CALC_CHAIN_EN: after 5+3=8, key A, operand 2, key C → op_a = 8, result 10. Without the macro, key A in SHOW leaves the state unchanged.
